// File: rtl/game_pkg.sv
// game_pkg: shared sprite-engine constants, FSM state codes and screen-bounds helper.
// Ports: none (package). RGB width comes from the GAME_RGB_WIDTH macro.
`ifndef GAME_RGB_WIDTH
`define GAME_RGB_WIDTH 12
`endif
package game_pkg;
    localparam int RGB_W    = `GAME_RGB_WIDTH;
    localparam int COORD_W  = 11;
    localparam int PIXEL_W  = 10;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] GONE   = 2'd2;
    // True when a w*h box at signed (x,y) has no pixel inside the sw*sh screen.
    // Widened to 12 bits so x+w cannot wrap.
    function automatic logic off_screen(input logic [10:0] x, input logic [10:0] y,
                                        input int w, input int h, input int sw, input int sh);
        logic signed [11:0] xe, ye;
        xe = signed'({x[10], x});
        ye = signed'({y[10], y});
        return (xe + signed'(12'(w)) <= 12'sd0) || (xe >= signed'(12'(sw))) ||
               (ye + signed'(12'(h)) <= 12'sd0) || (ye >= signed'(12'(sh)));
    endfunction
endpackage

// File: rtl/game_sprite_engine_if.sv
// game_sprite_engine_if: control/status bus between game logic (master) and a sprite engine (slave).
// Signals: write_xy/write_dxy load pulses, x0/y0 start position, dx0/dy0 velocity,
// enable_move, and status back: sprite_x/sprite_y/on_screen.
interface game_sprite_engine_if;
    logic               write_xy;
    logic               write_dxy;
    logic               enable_move;
    logic signed [10:0] x0;
    logic signed [10:0] y0;
    logic signed [3:0]  dx0;
    logic signed [3:0]  dy0;
    logic signed [10:0] sprite_x;
    logic signed [10:0] sprite_y;
    logic               on_screen;
    modport master (output write_xy, write_dxy, enable_move, x0, y0, dx0, dy0,
                    input  sprite_x, sprite_y, on_screen);
    modport slave  (input  write_xy, write_dxy, enable_move, x0, y0, dx0, dy0,
                    output sprite_x, sprite_y, on_screen);
endinterface

// File: rtl/game_sprite_rom.sv
// game_sprite_rom: registered 1-cycle lookup of a packed sprite image by (row,col).
// Ports: clk, rst (async, active-high), row/col in, word out (pixel colour).
module game_sprite_rom import game_pkg::*; #(
    parameter int W = 8,
    parameter int H = 8,
    parameter logic [W*H*RGB_W-1:0] ROM = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       row,
    input  logic [3:0]       col,
    output logic [RGB_W-1:0] word
);
    logic [8:0] idx;
    assign idx = 9'(row) * 9'(W) + 9'(col);
    // Indices past the image only occur when the box test missed; return 0 there.
    always_ff @(posedge clk or posedge rst)
        if (rst) word <= '0;
        else     word <= (int'(idx) < W * H) ? ROM[int'(idx) * RGB_W +: RGB_W] : '0;
endmodule

// File: rtl/game_sprite_engine.sv
// game_sprite_engine: one movable sprite; steps position every FRAMES_PER_STEP frames and
// renders it at the raster pixel with a fixed 2-cycle latency.
// Ports: clk, rst (async, active-high), pixel_x/pixel_y raster in, bus (slave control/status),
// rgb_en/rgb pixel out (rgb is 0 when rgb_en is 0).
module game_sprite_engine import game_pkg::*; #(
    parameter int SPRITE_W        = 8,
    parameter int SPRITE_H        = 8,
    parameter int SCREEN_W        = 640,
    parameter int SCREEN_H        = 480,
    parameter int FRAMES_PER_STEP = 1,
    parameter logic [SPRITE_W*SPRITE_H*RGB_W-1:0] SPRITE_ROM = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    game_sprite_engine_if.slave bus,
    output logic               rgb_en,
    output logic [RGB_W-1:0]   rgb
);
    logic [1:0]         state;
    logic [10:0]        sx, sy, nx, ny;
    logic [3:0]         dx, dy;
    logic [7:0]         frame_cnt;
    logic               tick_prev, at_tick, tick, step, on_scr;
    logic signed [11:0] rx, ry;
    logic               hit_c, hit1, hit2;
    logic [3:0]         row, col;
    logic [RGB_W-1:0]   word;

    // Frame boundary is the first cycle the raster sits at (0,SCREEN_H).
    assign at_tick = pixel_x == 10'd0 && pixel_y == 10'(SCREEN_H);
    assign tick    = at_tick && !tick_prev;
    assign step    = tick && frame_cnt == 8'(FRAMES_PER_STEP - 1);
    assign nx      = bus.enable_move ? sx + {{7{dx[3]}}, dx} : sx;
    assign ny      = bus.enable_move ? sy + {{7{dy[3]}}, dy} : sy;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            sx        <= '0;
            sy        <= '0;
            dx        <= '0;
            dy        <= '0;
            frame_cnt <= '0;
            tick_prev <= 1'b0;
            on_scr    <= 1'b0;
        end else begin
            tick_prev <= at_tick;
            on_scr    <= !off_screen(sx, sy, SPRITE_W, SPRITE_H, SCREEN_W, SCREEN_H);
            if (tick) frame_cnt <= step ? 8'd0 : frame_cnt + 8'd1;
            if (bus.write_dxy) begin
                dx <= bus.dx0;
                dy <= bus.dy0;
            end
            // A load in the same cycle as a step wins; the step is dropped.
            if (bus.write_xy) begin
                state <= ACTIVE;
                sx    <= bus.x0;
                sy    <= bus.y0;
            end else if (state == ACTIVE && step) begin
                sx <= nx;
                sy <= ny;
                if (off_screen(nx, ny, SPRITE_W, SPRITE_H, SCREEN_W, SCREEN_H)) state <= GONE;
            end
        end

    assign bus.sprite_x  = sx;
    assign bus.sprite_y  = sy;
    assign bus.on_screen = on_scr;

    // Offsets of the raster pixel inside the box; 12-bit signed so negative positions clip.
    assign rx    = signed'({2'b00, pixel_x}) - signed'({sx[10], sx});
    assign ry    = signed'({2'b00, pixel_y}) - signed'({sy[10], sy});
    assign hit_c = rx >= 12'sd0 && rx < signed'(12'(SPRITE_W)) &&
                   ry >= 12'sd0 && ry < signed'(12'(SPRITE_H));

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            hit1 <= 1'b0;
            hit2 <= 1'b0;
            row  <= '0;
            col  <= '0;
        end else begin
            hit1 <= hit_c;
            hit2 <= hit1;
            row  <= ry[3:0];
            col  <= rx[3:0];
        end

    game_sprite_rom #(.W(SPRITE_W), .H(SPRITE_H), .ROM(SPRITE_ROM)) u_rom (
        .clk  (clk),
        .rst  (rst),
        .row  (row),
        .col  (col),
        .word (word)
    );

    // Colour 0 is transparent.
    assign rgb_en = hit2 && state == ACTIVE && word != '0;
    assign rgb    = rgb_en ? word : '0;
endmodule

// File: tb/tb_game_sprite_engine.sv
// tb_game_sprite_engine: directed self-checking bench for game_sprite_engine (FRAMES_PER_STEP=2).
module tb_game_sprite_engine;
    import game_pkg::*;
    localparam int W = 8;
    localparam int H = 8;

    function automatic logic [RGB_W-1:0] pix(input int r, input int c);
        return (r == 2 && c == 3) ? '0 : RGB_W'(r * 16 + c + 1);
    endfunction

    function automatic logic [W*H*RGB_W-1:0] mk_rom();
        logic [W*H*RGB_W-1:0] v;
        v = '0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                v[(r * W + c) * RGB_W +: RGB_W] = pix(r, c);
        return v;
    endfunction

    localparam logic [W*H*RGB_W-1:0] ROM = mk_rom();

    typedef struct {
        int   px;
        int   py;
        logic en;
        int   col;
    } vec_t;

    logic             clk, rst;
    logic [9:0]       pixel_x, pixel_y;
    logic             rgb_en;
    logic [RGB_W-1:0] rgb;
    int               checks, failures;
    vec_t             vecs[8];

    game_sprite_engine_if bus ();

    game_sprite_engine #(.SPRITE_W(W), .SPRITE_H(H), .FRAMES_PER_STEP(2), .SPRITE_ROM(ROM)) dut (
        .clk     (clk),
        .rst     (rst),
        .pixel_x (pixel_x),
        .pixel_y (pixel_y),
        .bus     (bus),
        .rgb_en  (rgb_en),
        .rgb     (rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_xy(input int x, input int y);
        bus.x0 = 11'(x);
        bus.y0 = 11'(y);
        bus.write_xy = 1'b1;
        cyc();
        bus.write_xy = 1'b0;
    endtask

    task automatic load_dxy(input int dx, input int dy);
        bus.dx0 = 4'(dx);
        bus.dy0 = 4'(dy);
        bus.write_dxy = 1'b1;
        cyc();
        bus.write_dxy = 1'b0;
    endtask

    task automatic frame(input int hold);
        pixel_x = 10'd0;
        pixel_y = 10'd480;
        repeat (hold) cyc();
        pixel_x = 10'd5;
        pixel_y = 10'd5;
        cyc();
    endtask

    task automatic scan(input string name, input int x, input int y, input logic en, input int col);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        repeat (2) cyc();
        chk({name, "_en"}, int'(rgb_en), int'(en));
        chk({name, "_rgb"}, int'(rgb), col);
    endtask

    task automatic pos(input string name, input int x, input int y);
        chk({name, "_x"}, int'(bus.sprite_x), x);
        chk({name, "_y"}, int'(bus.sprite_y), y);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        vecs[0] = '{100, 50, 1'b1, 1};
        vecs[1] = '{107, 57, 1'b1, 120};
        vecs[2] = '{104, 51, 1'b1, 21};
        vecs[3] = '{103, 52, 1'b0, 0};
        vecs[4] = '{99, 50, 1'b0, 0};
        vecs[5] = '{108, 50, 1'b0, 0};
        vecs[6] = '{100, 49, 1'b0, 0};
        vecs[7] = '{100, 58, 1'b0, 0};
        rst = 1'b1;
        pixel_x = 10'd5;
        pixel_y = 10'd5;
        bus.write_xy = 1'b0;
        bus.write_dxy = 1'b0;
        bus.enable_move = 1'b0;
        bus.x0 = '0;
        bus.y0 = '0;
        bus.dx0 = '0;
        bus.dy0 = '0;
        repeat (2) cyc();
        pos("reset", 0, 0);
        chk("reset_on_screen", int'(bus.on_screen), 0);
        chk("reset_rgb_en", int'(rgb_en), 0);
        chk("reset_rgb", int'(rgb), 0);
        rst = 1'b0;
        cyc();
        scan("idle", 0, 0, 1'b0, 0);

        load_xy(100, 50);
        pos("load", 100, 50);
        for (int i = 0; i < 8; i++)
            scan($sformatf("vec%0d", i), vecs[i].px, vecs[i].py, vecs[i].en, vecs[i].col);

        load_dxy(3, -2);
        pos("dxy_only", 100, 50);
        bus.enable_move = 1'b1;
        frame(1);
        pos("f1", 100, 50);
        frame(1);
        pos("f2", 103, 48);
        frame(1);
        frame(1);
        pos("f4", 106, 46);
        frame(3);
        frame(3);
        pos("held", 109, 44);

        frame(1);
        pos("pre_tie", 109, 44);
        pixel_x = 10'd0;
        pixel_y = 10'd480;
        load_xy(200, 100);
        pixel_x = 10'd5;
        pixel_y = 10'd5;
        cyc();
        pos("tie", 200, 100);
        frame(1);
        pos("tie_f1", 200, 100);
        frame(1);
        pos("tie_f2", 203, 98);

        load_dxy(4, 0);
        load_xy(636, 50);
        cyc();
        chk("edge_on_screen", int'(bus.on_screen), 1);
        frame(1);
        frame(1);
        pos("gone", 640, 50);
        chk("gone_on_screen", int'(bus.on_screen), 0);
        scan("gone", 640, 50, 1'b0, 0);
        frame(1);
        frame(1);
        pos("gone_frozen", 640, 50);
        load_xy(10, 50);
        scan("redraw", 10, 50, 1'b1, 1);

        bus.enable_move = 1'b0;
        load_xy(-4, 50);
        cyc();
        chk("clip_on_screen", int'(bus.on_screen), 1);
        for (int c = 0; c < 4; c++)
            scan($sformatf("clip%0d", c), c, 50, 1'b1, int'(pix(0, c + 4)));
        scan("clip_out", 4, 50, 1'b0, 0);
        frame(1);
        frame(1);
        pos("no_move", -4, 50);

        scan("pre_rst", 1, 51, 1'b1, int'(pix(1, 5)));
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_en", int'(rgb_en), 0);
        chk("mid_rst_rgb", int'(rgb), 0);
        pos("mid_rst", 0, 0);
        #3 rst = 1'b0;
        scan("post_rst", 1, 51, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
